uart_result_tx: RTL

//   UART transmitter for systolic array results: the outbound counterpart to the operand path.
//   On the array's done pulse it snapshots C0..C15 and serialises them as an 8N1 byte frame on tx.

---
 rtl/uart_result_tx.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_result_tx.sv
// 8N1 UART transmitter that snapshots the systolic array results on done and sends HEADER, C0..C15.
// Define CHECKSUM_EN to append an XOR-of-payload checksum byte after C15.
module uart_result_tx #(
  parameter int unsigned REG_WIDTH    = 8,
  parameter int unsigned OUT_WIDTH    = REG_WIDTH * 2,
  parameter int unsigned NUM_RESULTS  = 16,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             done,
  input  logic [NUM_RESULTS*OUT_WIDTH-1:0] C_bus,
  output logic                             tx,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int unsigned BUS_W     = NUM_RESULTS * OUT_WIDTH;
  localparam int unsigned BPW       = OUT_WIDTH / 8;
  localparam int unsigned PAY_BYTES = NUM_RESULTS * BPW;
`ifdef CHECKSUM_EN
  localparam int unsigned NUM_BYTES = PAY_BYTES + 2;
`else
  localparam int unsigned NUM_BYTES = PAY_BYTES + 1;
`endif
  localparam int unsigned CLK_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BYTE_W = $clog2(NUM_BYTES);
  localparam int unsigned SEL_W  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t              state_q, state_n;
  logic                tx_q, tx_n;
  logic                busy_q, busy_n;
  logic                frame_done_q, frame_done_n;
  logic                done_d;
  logic [CLK_W-1:0]    clk_q, clk_n;
  logic [2:0]          bit_q, bit_n;
  logic [BYTE_W-1:0]   byte_q, byte_n;
  logic [SEL_W-1:0]    sel_q, sel_n;
  logic [BUS_W-1:0]    shadow_q, shadow_n;
  logic [7:0]          shift_q, shift_n;
  logic [7:0]          pay_byte;
  logic                bit_end;
`ifdef CHECKSUM_EN
  logic [7:0]          chk_q, chk_n;
`endif

  // Current payload byte: MSB byte first within the word at the bottom of the shadow.
  always_comb begin
    pay_byte = '0;
    for (int j = 0; j < BPW; j++) begin
      if (sel_q == SEL_W'(j)) pay_byte = shadow_q[(BPW-1-j)*8 +: 8];
    end
  end

  assign bit_end = (clk_q == CLK_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n      = state_q;
    tx_n         = tx_q;
    busy_n       = busy_q;
    frame_done_n = 1'b0;
    clk_n        = clk_q;
    bit_n        = bit_q;
    byte_n       = byte_q;
    sel_n        = sel_q;
    shadow_n     = shadow_q;
    shift_n      = shift_q;
`ifdef CHECKSUM_EN
    chk_n        = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (done && !done_d) begin
          state_n  = S_START;
          tx_n     = 1'b0;
          busy_n   = 1'b1;
          clk_n    = '0;
          byte_n   = '0;
          sel_n    = '0;
          shadow_n = C_bus;
          shift_n  = HEADER;
`ifdef CHECKSUM_EN
          chk_n    = '0;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_n   = '0;
          bit_n   = '0;
          state_n = S_DATA;
          tx_n    = shift_q[0];
          shift_n = {1'b0, shift_q[7:1]};
        end else begin
          clk_n = clk_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_n = '0;
          if (bit_q == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_q + 1'b1;
            tx_n    = shift_q[0];
            shift_n = {1'b0, shift_q[7:1]};
          end
        end else begin
          clk_n = clk_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_n = '0;
          if (byte_q == BYTE_W'(NUM_BYTES - 1)) begin
            state_n      = S_DONE;
            tx_n         = 1'b1;
            busy_n       = 1'b0;
            frame_done_n = 1'b1;
          end else begin
            // Next byte starts immediately: no idle gap between bytes.
            state_n = S_START;
            tx_n    = 1'b0;
            byte_n  = byte_q + 1'b1;
`ifdef CHECKSUM_EN
            if (byte_q == BYTE_W'(PAY_BYTES)) begin
              shift_n = chk_q;
            end else begin
              shift_n = pay_byte;
              chk_n   = chk_q ^ pay_byte;
              if (sel_q == SEL_W'(BPW - 1)) begin
                sel_n    = '0;
                shadow_n = shadow_q >> OUT_WIDTH;
              end else begin
                sel_n = sel_q + 1'b1;
              end
            end
`else
            shift_n = pay_byte;
            if (sel_q == SEL_W'(BPW - 1)) begin
              sel_n    = '0;
              shadow_n = shadow_q >> OUT_WIDTH;
            end else begin
              sel_n = sel_q + 1'b1;
            end
`endif
          end
        end else begin
          clk_n = clk_q + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      done_d       <= 1'b0;
      clk_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      sel_q        <= '0;
      shadow_q     <= '0;
      shift_q      <= '0;
`ifdef CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_n;
      tx_q         <= tx_n;
      busy_q       <= busy_n;
      frame_done_q <= frame_done_n;
      done_d       <= done;
      clk_q        <= clk_n;
      bit_q        <= bit_n;
      byte_q       <= byte_n;
      sel_q        <= sel_n;
      shadow_q     <= shadow_n;
      shift_q      <= shift_n;
`ifdef CHECKSUM_EN
      chk_q        <= chk_n;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
